// File: rtl/best_mode_picker.sv
// best_mode_picker: sequential RD search over enabled prediction modes, keeping the lowest-score candidate
module best_mode_picker #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 2,
  parameter int PAYLOAD_W = 3072,
  parameter int SCORE_W   = 64,
  parameter int SSE_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_MODES-1:0]    mode_mask,
  input  logic [31:0]             lambda,
  input  logic [16*NUM_MODES-1:0] fixed_cost,
  input  logic [SCORE_W-1:0]      early_thresh,
  output logic                    eval_start,
  output logic [MODE_W-1:0]       eval_mode,
  input  logic                    eval_done,
  input  logic [31:0]             eval_sse,
  input  logic [31:0]             eval_sum,
  input  logic [PAYLOAD_W-1:0]    eval_payload,
  output logic [MODE_W-1:0]       best_mode,
  output logic [SCORE_W-1:0]      best_score,
  output logic [PAYLOAD_W-1:0]    best_payload,
  output logic                    none_valid,
  output logic                    early_exit,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCORE, COMP, DONE} state_t;
  state_t                  state_q;
  logic [NUM_MODES-1:0]    rem_q;
  logic [MODE_W-1:0]       mode_q, best_mode_q, wb_mode_q;
  logic [31:0]             lam_q, sse_q, sum_q;
  logic [16*NUM_MODES-1:0] cost_q;
  logic [SCORE_W-1:0]      thresh_q, score_q, wb_score_q, best_score_q;
  logic [PAYLOAD_W-1:0]    pay_q, wb_pay_q, best_pay_q;
  logic                    first_q, eval_start_q, none_valid_q, early_exit_q, busy_q, done_q;
  logic [15:0]             cost_sel;
  logic [SCORE_W-1:0]      score_d, nb_score;
  logic [MODE_W-1:0]       nb_mode;
  logic [PAYLOAD_W-1:0]    nb_pay;
  logic                    take, early;

  function automatic logic [MODE_W-1:0] top_idx(input logic [NUM_MODES-1:0] m);
    top_idx = '0;
    for (int i = 0; i < NUM_MODES; i++) if (m[i]) top_idx = MODE_W'(i);
  endfunction

  assign eval_start   = eval_start_q;
  assign eval_mode    = mode_q;
  assign best_mode    = best_mode_q;
  assign best_score   = best_score_q;
  assign best_payload = best_pay_q;
  assign none_valid   = none_valid_q;
  assign early_exit   = early_exit_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // RD score of the captured candidate and the working best it would produce;
  // results are committed to best_* only when a search completes, so an aborted
  // search leaves the previous search's result visible
  always_comb begin
    cost_sel = cost_q[16*int'(mode_q) +: 16];
    score_d  = ((SCORE_W'(sum_q) << 10) + SCORE_W'(cost_sel)) * SCORE_W'(lam_q) + (SCORE_W'(sse_q) << SSE_SHIFT);
    take     = first_q || (score_q <= wb_score_q);
    nb_score = take ? score_q : wb_score_q;
    nb_mode  = take ? mode_q : wb_mode_q;
    nb_pay   = take ? pay_q : wb_pay_q;
    early    = (thresh_q != '0) && (nb_score < thresh_q);
  end

  // search sequencer with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      mode_q       <= '0;
      lam_q        <= '0;
      cost_q       <= '0;
      thresh_q     <= '0;
      sse_q        <= '0;
      sum_q        <= '0;
      pay_q        <= '0;
      score_q      <= '0;
      first_q      <= 1'b0;
      wb_mode_q    <= '0;
      wb_score_q   <= '0;
      wb_pay_q     <= '0;
      best_mode_q  <= '0;
      best_score_q <= '0;
      best_pay_q   <= '0;
      eval_start_q <= 1'b0;
      none_valid_q <= 1'b0;
      early_exit_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      eval_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            none_valid_q <= 1'b0;
            early_exit_q <= 1'b0;
            lam_q        <= lambda[31] ? 32'd0 : lambda;
            cost_q       <= fixed_cost;
            thresh_q     <= early_thresh;
            rem_q        <= mode_mask;
            first_q      <= 1'b1;
            if (|mode_mask) begin
              state_q      <= ISSUE;
              busy_q       <= 1'b1;
              mode_q       <= top_idx(mode_mask);
              eval_start_q <= 1'b1;
            end else begin
              state_q      <= DONE;
              none_valid_q <= 1'b1;
              done_q       <= 1'b1;
            end
          end
          ISSUE: begin
            rem_q   <= rem_q & ~(NUM_MODES'(1) << mode_q);
            state_q <= WAIT;
          end
          WAIT: if (eval_done) begin
            sse_q   <= eval_sse;
            sum_q   <= eval_sum;
            pay_q   <= eval_payload;
            state_q <= SCORE;
          end
          SCORE: begin
            score_q <= score_d;
            state_q <= COMP;
          end
          COMP: begin
            first_q    <= 1'b0;
            wb_score_q <= nb_score;
            wb_mode_q  <= nb_mode;
            wb_pay_q   <= nb_pay;
            if (early || rem_q == '0) begin
              state_q      <= DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              early_exit_q <= early;
              best_score_q <= nb_score;
              best_mode_q  <= nb_mode;
              best_pay_q   <= nb_pay;
            end else begin
              state_q      <= ISSUE;
              mode_q       <= top_idx(rem_q);
              eval_start_q <= 1'b1;
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
